button_cmd_arbiter: RTL and testbench
=====================================

Name: button_cmd_arbiter

Overview:
Round-robin arbiter that shares one command-driven datapath resource among N_REQ push-button requesters.
- Each requester is a raw active-low level, pressed = 0.
- The block detects each press once, in the same manner as the team's single-pulse button logic, and queues it as a pending request.
- Pending requests are granted one at a time through a start/done handshake with the shared resource.
- Sits between the button inputs and the shared datapath controller.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEL_W, 2, width of grant_sel; must satisfy 2**SEL_W >= N_REQ
TIMEOUT_CYC, 255, cycles in WAIT before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_n  input  N_REQ  active-low requester levels, already synchronous to clk
done  input  1  resource finished the current command; sampled only in WAIT
start  output  1  one-cycle high pulse launching the resource for grant_sel
grant_sel  output  SEL_W  index of the current or last granted requester
grant_vec  output  N_REQ  one-hot of the granted requester while busy, else 0
busy  output  1  high in ISSUE and WAIT
pending  output  N_REQ  queued-request bits
drop  output  1  one-cycle pulse: a press arrived for a requester whose pending bit was already set
timeout  output  1  one-cycle pulse on watchdog abort; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, immediate):
  - state = IDLE; pending = 0; start = 0; busy = 0; grant_vec = 0; grant_sel = 0; drop = 0; timeout = 0.
  - req_prev = all 1 (released).
  - last_grant = N_REQ-1, so requester 0 has first priority.
- Press detect, per bit i:
  - press_i = req_prev[i] & ~req_n[i]; req_prev <= req_n every cycle.
  - Holding a button low produces exactly one press; releasing produces nothing.
- Pending update, per bit i, each edge:
  - If press_i: set pending[i].
  - Else if the bit is being cleared in ISSUE for requester i: clear it.
  - Press and clear in the same cycle: set wins, and the press is queued as a new request (no drop).
  - Press while pending[i] is already 1 and not being cleared: pending unchanged; drop = 1 for one cycle.
- FSM, three states:
  - IDLE: if pending != 0, choose the first set bit scanning last_grant+1, last_grant+2, ... modulo N_REQ. Latch it into grant_sel and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE, exactly one cycle: start = 1; clear pending[grant_sel]; go to WAIT. A done asserted during ISSUE is ignored.
  - WAIT: on done = 1, set last_grant = grant_sel and go to IDLE. Otherwise stay.
- Outputs:
  - grant_vec = one-hot(grant_sel) in ISSUE and WAIT, else 0.
  - busy = (state != IDLE).
- Latency: a press sampled at edge t gives pending[i] = 1 after edge t. With the arbiter idle, start is high in the cycle following edge t+1, i.e. 2 cycles after the press edge.
- Back-to-back grants: done at edge d leads to IDLE; the next start is high after edge d+1. Minimum grant period is 3 cycles, given done in the first WAIT cycle.
- Fairness: a requester pressing continuously waits at most N_REQ-1 other grants.
- Reset mid-operation: the command is abandoned, start is not reissued, and all queued requests are lost.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYC+1)) is cleared on entry to WAIT and increments each WAIT cycle without done.
  - When it reaches TIMEOUT_CYC, without done in that same cycle: timeout = 1 for one cycle; last_grant = grant_sel; state → IDLE. The request is not requeued.
  - If done and the expiry coincide, done wins and timeout stays 0.
- Undefined:
  - No counter is built; WAIT holds until done; timeout is tied to 0.

Test Plan:
- Reset, then req_n[0] from 1 to 0 and held → start high for exactly one cycle 2 cycles later; grant_sel = 0; grant_vec = 0001; busy stays 1 until done; no second start while the button is held.
- req_n = 0000 pressed in the same cycle, with done returned 1 cycle after each start → grant order 0, 1, 2, 3; pending goes 1111 → 1110 → 1100 → 1000 → 0000.
- While requester 2 is in WAIT, press 2 again and then a third time → pending[2] = 1 after the second press, drop pulses once on the third; requester 2 is granted again after the current done.
- Press 1 in exactly the ISSUE cycle of requester 1 → pending[1] stays 1, drop = 0; requester 1 is regranted after done.
- Assert rst asynchronously mid-WAIT with pending = 0110 → all outputs 0 immediately, pending = 0; the next press of 3 is granted with no stale start.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC = 4, never assert done → timeout pulses at the 4th WAIT cycle and the arbiter returns to IDLE. Repeat with done on that same cycle → timeout = 0.

Source files
------------

// File: rtl/button_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// button_cmd_arbiter
//   Round-robin arbiter sharing one command-driven resource among N_REQ
//   push-button requesters. Each falling edge of an active-low button level is
//   detected once and queued as a pending request; pending requests are granted
//   one at a time through a start/done handshake.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   req_n      in   [N_REQ] active-low requester levels (synchronous to clk)
//   done       in   resource finished current command, sampled only in WAIT
//   start      out  one-cycle pulse launching the resource for grant_sel
//   grant_sel  out  [SEL_W] index of the current or last granted requester
//   grant_vec  out  [N_REQ] one-hot grant while busy, else 0
//   busy       out  high in ISSUE and WAIT
//   pending    out  [N_REQ] queued-request bits
//   drop       out  pulse: press arrived while that requester was already queued
//   timeout    out  pulse on watchdog abort (0 unless ARB_TIMEOUT_EN)
//
// Configuration macro:
//   ARB_TIMEOUT_EN  builds a WAIT watchdog of TIMEOUT_CYC cycles.
// -----------------------------------------------------------------------------
module button_cmd_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_n,
  input  logic             done,
  output logic             start,
  output logic [SEL_W-1:0] grant_sel,
  output logic [N_REQ-1:0] grant_vec,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic             drop,
  output logic             timeout
);

  // Reject configurations grant_sel cannot address or the watchdog cannot count.
  if ((2**SEL_W < N_REQ) || (N_REQ < 2) || (N_REQ > 8) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
    $error("button_cmd_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] last_grant_q;
  logic [SEL_W-1:0] grant_sel_q;
  logic [N_REQ-1:0] grant_vec_q;
  logic             start_q;
  logic             busy_q;
  logic             timeout_q;
  logic [N_REQ-1:0] req_prev_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic             drop_q;
  logic             drop_d;
  logic [N_REQ-1:0] press_s;
  logic [N_REQ-1:0] clr_s;
  logic [SEL_W:0]   pick_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Value seen in the last permitted WAIT cycle; the abort edge takes it to TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt_q;
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    return {{(N_REQ-1){1'b0}}, 1'b1} << sel;
  endfunction

  // Returns {found, index} of the first set bit scanning last+1, last+2, ...
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] pend,
                                             input logic [SEL_W-1:0] last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] cand;
    res = {1'b0, {SEL_W{1'b0}}};
    for (int k = N_REQ; k >= 1; k--) begin
      cand = SEL_W'((int'(last) + k) % N_REQ);
      if (pend[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Press detection, pending set/clear (set wins) and drop detection.
  always_comb begin
    clr_s     = {N_REQ{1'b0}};
    if (state_q == ST_ISSUE) begin
      clr_s = onehot(grant_sel_q);
    end else begin
      clr_s = {N_REQ{1'b0}};
    end
    press_s   = req_prev_q & ~req_n;
    pending_d = (pending_q & ~clr_s) | press_s;
    drop_d    = |(press_s & pending_q & ~clr_s);
    pick_s    = rr_pick(pending_q, last_grant_q);
  end

  // Button history, request queue and drop pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= {N_REQ{1'b1}};
      pending_q  <= {N_REQ{1'b0}};
      drop_q     <= 1'b0;
    end else begin
      req_prev_q <= req_n;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  // Grant FSM with registered handshake and grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SEL_W'(N_REQ - 1);
      grant_sel_q  <= {SEL_W{1'b0}};
      grant_vec_q  <= {N_REQ{1'b0}};
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_s[SEL_W]) begin
            grant_sel_q <= pick_s[SEL_W-1:0];
            grant_vec_q <= onehot(pick_s[SEL_W-1:0]);
            start_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            grant_vec_q <= {N_REQ{1'b0}};
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // done is deliberately ignored here; the command has only just launched.
          start_q <= 1'b0;
          state_q <= ST_WAIT;
`ifdef ARB_TIMEOUT_EN
          wait_cnt_q <= {CNT_W{1'b0}};
`endif
        end
        ST_WAIT: begin
          if (done) begin
            last_grant_q <= grant_sel_q;
            grant_vec_q  <= {N_REQ{1'b0}};
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (wait_cnt_q == CNT_LAST) begin
            // Abandon the command; the request is not requeued.
            wait_cnt_q   <= wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            timeout_q    <= 1'b1;
            last_grant_q <= grant_sel_q;
            grant_vec_q  <= {N_REQ{1'b0}};
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            wait_cnt_q   <= wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q      <= ST_WAIT;
          end
`else
          end else begin
            state_q      <= ST_WAIT;
          end
`endif
        end
        default: begin
          grant_vec_q <= {N_REQ{1'b0}};
          start_q     <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign start     = start_q;
  assign grant_sel = grant_sel_q;
  assign grant_vec = grant_vec_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign drop      = drop_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_cmd_arbiter
//   Directed, table-driven bench for button_cmd_arbiter (N_REQ=4, SEL_W=2,
//   TIMEOUT_CYC=6). Each table row gives the inputs for one clock edge and the
//   outputs expected just after it; hand-written sequences cover async reset
//   and the watchdog.
// -----------------------------------------------------------------------------
module tb_button_cmd_arbiter;

  localparam int TO = 6;

  logic       clk;
  logic       rst;
  logic [3:0] req_n;
  logic       done;
  logic       start;
  logic [1:0] grant_sel;
  logic [3:0] grant_vec;
  logic       busy;
  logic [3:0] pending;
  logic       drop;
  logic       timeout;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [3:0] req_n;
    logic       done;
    logic       start;
    logic       busy;
    logic [1:0] sel;
    logic [3:0] vec;
    logic [3:0] pend;
    logic       drop;
  } vec_t;

  vec_t tv[$];

  button_cmd_arbiter #(
    .N_REQ      (4),
    .SEL_W      (2),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_n    (req_n),
    .done     (done),
    .start    (start),
    .grant_sel(grant_sel),
    .grant_vec(grant_vec),
    .busy     (busy),
    .pending  (pending),
    .drop     (drop),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic s, input logic b, input logic [1:0] sl,
                     input logic [3:0] gv, input logic [3:0] pd, input logic dr);
    vec_t v;
    v.rst = r; v.req_n = rq; v.done = d; v.start = s; v.busy = b;
    v.sel = sl; v.vec = gv; v.pend = pd; v.drop = dr;
    tv.push_back(v);
  endtask

  // Drive inputs for one edge, then sample 1 time unit after it.
  task automatic step(input logic [3:0] rq, input logic d);
    req_n = rq;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'b1111, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req_n   = 4'b1111;
    done    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start", -1, {7'd0, start}, 8'd0);
    chk("rst_busy",  -1, {7'd0, busy}, 8'd0);
    chk("rst_pend",  -1, {4'd0, pending}, 8'd0);
    rst = 1'b0;

    // rst, req_n, done | start, busy, sel, vec, pend, drop
    // Single press of requester 0, held: one start, no regrant.
    add(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    add(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
    add(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);
    add(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);
    add(1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    // All four pressed together: grant order 0,1,2,3.
    add(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b1110, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1110, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b1110, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b1100, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b1100, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b1100, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0);
    // Requester 2 re-pressed twice during WAIT: queue then drop.
    add(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
    add(1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0);
    add(1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0);
    // Requester 1 pressed in its own ISSUE cycle: set wins, no drop.
    add(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0);
    add(1'b0, 4'b1101, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0010, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst;
      step(tv[i].req_n, tv[i].done);
      rst = 1'b0;
      chk("start",     i, {7'd0, start},     {7'd0, tv[i].start});
      chk("busy",      i, {7'd0, busy},      {7'd0, tv[i].busy});
      chk("grant_sel", i, {6'd0, grant_sel}, {6'd0, tv[i].sel});
      chk("grant_vec", i, {4'd0, grant_vec}, {4'd0, tv[i].vec});
      chk("pending",   i, {4'd0, pending},   {4'd0, tv[i].pend});
      chk("drop",      i, {7'd0, drop},      {7'd0, tv[i].drop});
      chk("timeout",   i, {7'd0, timeout},   8'd0);
    end

    // Async reset mid-WAIT with pending 0110, then a fresh press of 3.
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("arst_pre_pend", 100, {4'd0, pending}, 8'h06);
    chk("arst_pre_busy", 100, {7'd0, busy}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 101, {7'd0, busy}, 8'd0);
    chk("arst_vec",  101, {4'd0, grant_vec}, 8'd0);
    chk("arst_sel",  101, {6'd0, grant_sel}, 8'd0);
    chk("arst_pend", 101, {4'd0, pending}, 8'd0);
    chk("arst_start", 101, {7'd0, start}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0111, 1'b0);
    chk("arst_p3_pend",  102, {4'd0, pending}, 8'h08);
    chk("arst_p3_start", 102, {7'd0, start}, 8'd0);
    step(4'b0111, 1'b0);
    chk("arst_p3_start", 103, {7'd0, start}, 8'd1);
    chk("arst_p3_sel",   103, {6'd0, grant_sel}, 8'd3);
    chk("arst_p3_vec",   103, {4'd0, grant_vec}, 8'h08);
    step(4'b0111, 1'b1);
    step(4'b0111, 1'b1);
    chk("arst_p3_done", 104, {7'd0, busy}, 8'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog fires after TO WAIT cycles without done.
    do_reset();
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(4'b1110, 1'b0);
      chk("to_pulse", 200 + k, {7'd0, timeout}, (k == TO) ? 8'd1 : 8'd0);
      chk("to_busy",  200 + k, {7'd0, busy},    (k == TO) ? 8'd0 : 8'd1);
    end
    step(4'b1110, 1'b0);
    chk("to_after",       210, {7'd0, timeout}, 8'd0);
    chk("to_no_requeue",  210, {7'd0, start}, 8'd0);
    // Done coinciding with expiry wins.
    step(4'b1111, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(4'b1110, (k == TO) ? 1'b1 : 1'b0);
      chk("to_done_pulse", 220 + k, {7'd0, timeout}, 8'd0);
      chk("to_done_busy",  220 + k, {7'd0, busy}, (k == TO) ? 8'd0 : 8'd1);
    end
`else
    // Without the watchdog, WAIT holds indefinitely and timeout stays 0.
    do_reset();
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    for (int k = 1; k <= 2 * TO; k++) begin
      step(4'b1110, 1'b0);
      chk("nto_pulse", 200 + k, {7'd0, timeout}, 8'd0);
      chk("nto_busy",  200 + k, {7'd0, busy}, 8'd1);
    end
    step(4'b1110, 1'b1);
    chk("nto_done", 230, {7'd0, busy}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
